mips_multicycle_controller: RTL and testbench

Moore control FSM for the multi-cycle MIPS datapath. It replaces the single-cycle opcode decode with a per-instruction state sequence that drives PC, IR, memory, register-file and ALU mux selects cycle by cycle. Memory-access states stall on a memory-ready handshake. It sits between the instruction register's opcode field and the shared datapath; the ALU function decoder consumes its ALUOp.

---
 rtl/mips_ctrl_pkg.sv | 62 ++++++
 rtl/mc_ctrl_outputs.sv | 88 ++++++++
 rtl/mips_multicycle_controller.sv | 84 ++++++++
 tb/tb_mips_multicycle_controller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes,
// datapath mux selects and the packed control word.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_SUB   = 3'b001;
   localparam logic [2:0] ALUOP_FUNCT = 3'b010;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   typedef struct packed {
      logic       pc_write;
      logic       branch;
      logic [1:0] pc_src;
      logic       i_or_d;
      logic       ir_write;
      logic       mem_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       instr_done;
      logic       illegal_op;
   } ctrl_t;

   function automatic logic is_legal_op(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
   endfunction

endpackage

// File: rtl/mc_ctrl_outputs.sv
// Moore output decode: current state (plus mem_ready in the memory handshake
// states) to the datapath control word. Purely combinational.
module mc_ctrl_outputs
   import mips_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic       mem_ready,
   input  logic [5:0] opcode,
   input  logic       reset,
   output ctrl_t      ctrl
);

   always_comb begin
      // NOTE: every field gets a default before the case so no latch can form.
      ctrl = '0;
      unique case (state)
         S_FETCH: begin
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.pc_src    = PCSRC_ALU;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b  = SRCB_IMM_SH2;
            ctrl.alu_op     = ALUOP_ADD;
            ctrl.illegal_op = !is_legal_op(opcode);
         end
         S_MEMADR, S_ADDIEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEMRD:
            ctrl.i_or_d = 1'b1;
         S_MEMWB: begin
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_MEMWR: begin
            ctrl.i_or_d     = 1'b1;
            ctrl.mem_write  = 1'b1;
            ctrl.instr_done = mem_ready;
         end
         S_EXECUTE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_RT;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            ctrl.reg_dst    = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = SRCB_RT;
            ctrl.alu_op     = ALUOP_SUB;
            ctrl.branch     = 1'b1;
            ctrl.pc_src     = PCSRC_ALUOUT;
            ctrl.instr_done = 1'b1;
         end
         S_ADDIWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_JUMP: begin
            ctrl.pc_write   = 1'b1;
            ctrl.pc_src     = PCSRC_JUMP;
            ctrl.instr_done = 1'b1;
         end
         default: ctrl = '0;
      endcase

      // Architectural side effects must not leak out while reset is asserted.
      if (reset) begin
         ctrl.pc_write   = 1'b0;
         ctrl.ir_write   = 1'b0;
         ctrl.mem_write  = 1'b0;
         ctrl.reg_write  = 1'b0;
         ctrl.branch     = 1'b0;
         ctrl.instr_done = 1'b0;
         ctrl.illegal_op = 1'b0;
      end
   end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS control FSM: state register and next-state logic; the
// per-state control word comes from mc_ctrl_outputs.
module mips_multicycle_controller
   import mips_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       Branch,
   output logic [1:0] PCSrc,
   output logic       IorD,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUOp,
   output logic       instr_done,
   output logic       illegal_op,
   output logic [3:0] state
);

   state_t state_q;
   state_t state_d;
   ctrl_t  ctrl;

   // NOTE: sequential state uses non-blocking assignment so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      unique case (state_q)
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            unique case (Opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:  state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_EXECUTE: state_d = S_ALUWB;
         S_ADDIEX:  state_d = S_ADDIWB;
         default:   state_d = S_FETCH;
      endcase
   end

   mc_ctrl_outputs u_outputs (
      .state     (state_q),
      .mem_ready (mem_ready),
      .opcode    (Opcode),
      .reset     (reset),
      .ctrl      (ctrl)
   );

   assign PCWrite    = ctrl.pc_write;
   assign Branch     = ctrl.branch;
   assign PCSrc      = ctrl.pc_src;
   assign IorD       = ctrl.i_or_d;
   assign IRWrite    = ctrl.ir_write;
   assign MemWrite   = ctrl.mem_write;
   assign RegDst     = ctrl.reg_dst;
   assign MemtoReg   = ctrl.mem_to_reg;
   assign RegWrite   = ctrl.reg_write;
   assign ALUSrcA    = ctrl.alu_src_a;
   assign ALUSrcB    = ctrl.alu_src_b;
   assign ALUOp      = ctrl.alu_op;
   assign instr_done = ctrl.instr_done;
   assign illegal_op = ctrl.illegal_op;
   assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed self-checking bench for mips_multicycle_controller; all expected
// values are hand-derived constants from the state table.
module tb_mips_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] Opcode;
   logic       mem_ready;
   logic       PCWrite, Branch, IorD, IRWrite, MemWrite, RegDst, MemtoReg;
   logic       RegWrite, ALUSrcA, instr_done, illegal_op;
   logic [1:0] PCSrc, ALUSrcB;
   logic [2:0] ALUOp;
   logic [3:0] state;

   int checks   = 0;
   int failures = 0;

   mips_multicycle_controller dut (
      .clk        (clk),
      .reset      (reset),
      .Opcode     (Opcode),
      .mem_ready  (mem_ready),
      .PCWrite    (PCWrite),
      .Branch     (Branch),
      .PCSrc      (PCSrc),
      .IorD       (IorD),
      .IRWrite    (IRWrite),
      .MemWrite   (MemWrite),
      .RegDst     (RegDst),
      .MemtoReg   (MemtoReg),
      .RegWrite   (RegWrite),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ALUOp      (ALUOp),
      .instr_done (instr_done),
      .illegal_op (illegal_op),
      .state      (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one instruction starting in FETCH; returns cycles up to and including instr_done.
   task automatic run_instr(input logic [5:0] op, output int cycles);
      cycles = 0;
      Opcode = op;
      for (int i = 0; i < 20; i++) begin
         cycles++;
         if (state == 4'd6)  check("execute_aluop", ALUOp, 3'b010);
         if (state == 4'd8)  check("branch_aluop", ALUOp, 3'b001);
         if (state == 4'd8)  check("branch_pcsrc", PCSrc, 2'b01);
         if (state == 4'd11) check("jump_pcsrc", PCSrc, 2'b10);
         if (instr_done) break;
         tick();
      end
      tick();
      check("after_instr_fetch", state, 4'd0);
   endtask

   int c_r, c_addi, c_beq, c_j;

   initial begin
      reset = 1'b1; mem_ready = 1'b1; Opcode = 6'b000000;
      tick(); tick();
      check("reset_state", state, 4'd0);
      check("reset_irwrite_forced", IRWrite, 1'b0);
      check("reset_pcwrite_forced", PCWrite, 1'b0);
      reset = 1'b0; #1;

      // lw, zero-wait
      Opcode = 6'b100011;
      check("lw_s0_state", state, 4'd0);
      check("lw_s0_irwrite", IRWrite, 1'b1);
      check("lw_s0_pcwrite", PCWrite, 1'b1);
      check("lw_s0_alusrcb", ALUSrcB, 2'b01);
      tick();
      check("lw_s1_state", state, 4'd1);
      check("lw_s1_alusrcb", ALUSrcB, 2'b11);
      check("lw_s1_regwrite", RegWrite, 1'b0);
      tick();
      check("lw_s2_state", state, 4'd2);
      check("lw_s2_alusrca", ALUSrcA, 1'b1);
      check("lw_s2_alusrcb", ALUSrcB, 2'b10);
      tick();
      check("lw_s3_state", state, 4'd3);
      check("lw_s3_iord", IorD, 1'b1);
      check("lw_s3_regwrite", RegWrite, 1'b0);
      check("lw_s3_done", instr_done, 1'b0);
      tick();
      check("lw_s4_state", state, 4'd4);
      check("lw_s4_regwrite", RegWrite, 1'b1);
      check("lw_s4_memtoreg", MemtoReg, 1'b1);
      check("lw_s4_done", instr_done, 1'b1);
      tick();
      check("lw_end_state", state, 4'd0);
      check("lw_end_done", instr_done, 1'b0);
      check("lw_end_memtoreg", MemtoReg, 1'b0);

      // sw with three wait cycles in MEMWR
      Opcode = 6'b101011;
      tick(); tick();
      check("sw_memadr_state", state, 4'd2);
      mem_ready = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         check("sw_wait_state", state, 4'd5);
         check("sw_wait_memwrite", MemWrite, 1'b1);
         check("sw_wait_done", instr_done, 1'b0);
         tick();
      end
      mem_ready = 1'b1; #1;
      check("sw_ready_memwrite", MemWrite, 1'b1);
      check("sw_ready_done", instr_done, 1'b1);
      check("sw_ready_iord", IorD, 1'b1);
      tick();
      check("sw_end_state", state, 4'd0);
      check("sw_end_memwrite", MemWrite, 1'b0);

      // R, addi, beq, j back to back
      run_instr(6'b000000, c_r);
      run_instr(6'b001000, c_addi);
      run_instr(6'b000100, c_beq);
      run_instr(6'b000010, c_j);
      check("rtype_cycles", c_r, 4);
      check("addi_cycles", c_addi, 4);
      check("beq_cycles", c_beq, 3);
      check("j_cycles", c_j, 3);
      check("seq_total_cycles", c_r + c_addi + c_beq + c_j, 14);

      // illegal opcode
      Opcode = 6'b111111;
      tick();
      check("illegal_state", state, 4'd1);
      check("illegal_pulse", illegal_op, 1'b1);
      check("illegal_regwrite", RegWrite, 1'b0);
      check("illegal_memwrite", MemWrite, 1'b0);
      check("illegal_done", instr_done, 1'b0);
      tick();
      check("illegal_next_state", state, 4'd0);
      check("illegal_pulse_end", illegal_op, 1'b0);

      // FETCH stalled five cycles
      mem_ready = 1'b0; #1;
      for (int i = 0; i < 5; i++) begin
         check("fetch_wait_state", state, 4'd0);
         check("fetch_wait_pcwrite", PCWrite, 1'b0);
         check("fetch_wait_irwrite", IRWrite, 1'b0);
         tick();
      end
      mem_ready = 1'b1; #1;
      check("fetch_go_pcwrite", PCWrite, 1'b1);
      check("fetch_go_irwrite", IRWrite, 1'b1);
      Opcode = 6'b101011;
      tick();
      check("fetch_go_decode", state, 4'd1);
      check("fetch_go_irwrite_once", IRWrite, 1'b0);

      // Reset held three cycles while stalled in MEMWR
      tick();
      mem_ready = 1'b0;
      tick();
      check("rst_pre_state", state, 4'd5);
      check("rst_pre_memwrite", MemWrite, 1'b1);
      reset = 1'b1; mem_ready = 1'b1; #1;
      check("rst_forced_memwrite", MemWrite, 1'b0);
      check("rst_forced_done", instr_done, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_hold_state", state, 4'd0);
         check("rst_hold_memwrite", MemWrite, 1'b0);
         check("rst_hold_irwrite", IRWrite, 1'b0);
      end
      reset = 1'b0; #1;
      check("rst_release_irwrite", IRWrite, 1'b1);
      tick();
      check("rst_release_decode", state, 4'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
